// File: rtl/pipe_sum_tree_acc_pkg.sv
// Shared definitions for the pipelined sum-tree accumulator: width helpers and the
// output clamp used when the SUM_TREE_SAT_EN build option is enabled.
package pipe_sum_tree_acc_pkg;

  localparam int WORD_LEN_DEFAULT = 32;
  localparam int SAT_MAX_W        = 128;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] value;
    logic                 sat;
  } sat_result_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Tree growth plus guard bits, so many tree sums can accumulate before wrapping.
  function automatic int acc_width(input int word_len, input int lanes, input int guard);
    return word_len + clog2(lanes) + guard;
  endfunction

  function automatic sat_result_t saturate(input logic signed [SAT_MAX_W-1:0] value,
                                           input int word_len);
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    sat_result_t                 res;
    max_v     = (SAT_MAX_W'(1) << (word_len - 1)) - SAT_MAX_W'(1);
    min_v     = ~max_v;
    res.value = value;
    res.sat   = 1'b0;
    if (value > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (value < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_sum_tree_acc_sum_tree_level.sv
// One registered level of the reduction tree: adds adjacent lane pairs losslessly
// (one bit of growth) and carries the beat's valid/last flags alongside.
module sum_tree_level #(
  parameter int IN_W  = 32,
  parameter int PAIRS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [2*PAIRS*IN_W-1:0]   in_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [PAIRS*(IN_W+1)-1:0] out_data
);

  logic [PAIRS*(IN_W+1)-1:0] sums;

  always_comb begin
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    sums = '0;
    for (int p = 0; p < PAIRS; p++) begin
      a = in_data[(2*p)*IN_W +: IN_W];
      b = in_data[(2*p+1)*IN_W +: IN_W];
      sums[p*(IN_W+1) +: IN_W+1] = {a[IN_W-1], a} + {b[IN_W-1], b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= sums;
    end
  end

endmodule

// File: rtl/pipe_sum_tree_acc.sv
// Pipelined dot-product reduction: input register, registered adder tree, vector accumulator.
// Build option SUM_TREE_SAT_EN clamps the scaled result to WORD_LEN instead of wrapping.
module pipe_sum_tree_acc
  import pipe_sum_tree_acc_pkg::*;
#(
  parameter int WORD_LEN  = WORD_LEN_DEFAULT,
  parameter int LANES     = 8,
  parameter int ACC_GUARD = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [LANES*WORD_LEN-1:0] in_data,
  output logic                      out_valid,
  output logic [WORD_LEN-1:0]       out_data,
  output logic                      out_sat
);

  localparam int LEVELS = clog2(LANES);
  localparam int ACC_W  = acc_width(WORD_LEN, LANES, ACC_GUARD);
  localparam int TREE_W = WORD_LEN + LEVELS;

  logic                      in_valid_q;
  logic                      in_last_q;
  logic [LANES*WORD_LEN-1:0] in_data_q;
  logic [LEVELS:0]           lvl_valid;
  logic [LEVELS:0]           lvl_last;

  // Input register gives the tree a clean launch point; it is one of the LEVELS+1 latency stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_last_q  <= 1'b0;
      in_data_q  <= '0;
    end else begin
      in_valid_q <= in_valid;
      in_last_q  <= in_last;
      in_data_q  <= in_data;
    end
  end

  assign lvl_valid[0] = in_valid_q;
  assign lvl_last[0]  = in_last_q;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int IN_W  = WORD_LEN + k;
    localparam int PAIRS = LANES >> (k + 1);

    logic [2*PAIRS*IN_W-1:0]   stage_in;
    logic [PAIRS*(IN_W+1)-1:0] stage_out;

    if (k == 0) begin : g_first
      assign stage_in = in_data_q;
    end else begin : g_next
      assign stage_in = g_level[k-1].stage_out;
    end

    sum_tree_level #(
      .IN_W  (IN_W),
      .PAIRS (PAIRS)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (lvl_valid[k]),
      .in_last   (lvl_last[k]),
      .in_data   (stage_in),
      .out_valid (lvl_valid[k+1]),
      .out_last  (lvl_last[k+1]),
      .out_data  (stage_out)
    );
  end

  logic [TREE_W-1:0]       tree_sum;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] shifted;
  logic                    first;
  logic [WORD_LEN-1:0]     narrow;
  logic                    narrow_sat;

  assign tree_sum = g_level[LEVELS-1].stage_out;

  // Accumulator wraps modulo 2^ACC_W by construction; shift is a floor (arithmetic) rescale.
  always_comb begin
    sum_ext  = {{(ACC_W-TREE_W){tree_sum[TREE_W-1]}}, tree_sum};
    acc_next = first ? sum_ext : acc + sum_ext;
    shifted  = acc_next >>> OUT_SHIFT;
  end

`ifdef SUM_TREE_SAT_EN
  sat_result_t sat_res;

  always_comb begin
    sat_res    = saturate({{(SAT_MAX_W-ACC_W){shifted[ACC_W-1]}}, shifted}, WORD_LEN);
    narrow     = sat_res.value[WORD_LEN-1:0];
    narrow_sat = sat_res.sat;
  end
`else
  always_comb begin
    narrow     = shifted[WORD_LEN-1:0];
    narrow_sat = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (lvl_valid[LEVELS]) begin
        acc   <= acc_next;
        first <= lvl_last[LEVELS];
        if (lvl_last[LEVELS]) begin
          out_valid <= 1'b1;
          out_data  <= narrow;
        end
      end
    end
  end

`ifdef SUM_TREE_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sat <= 1'b0;
    end else if (lvl_valid[LEVELS] && lvl_last[LEVELS]) begin
      out_sat <= narrow_sat;
    end
  end
`else
  assign out_sat = narrow_sat;
`endif

endmodule

// File: tb/tb_pipe_sum_tree_acc.sv
// Self-checking bench for pipe_sum_tree_acc: two instances (OUT_SHIFT 0 and 1) against a
// vector-level arithmetic model, plus directed literal checks. Honours SUM_TREE_SAT_EN.
module tb_pipe_sum_tree_acc;

  localparam int W     = 32;
  localparam int LANES = 8;
  localparam int GUARD = 8;
  localparam int ACC_W = W + $clog2(LANES) + GUARD;
  localparam int LAT   = $clog2(LANES) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_last;
  logic [LANES*W-1:0] in_data;
  logic               out_valid0, out_sat0, out_valid1, out_sat1;
  logic [W-1:0]       out_data0, out_data1;

  int checks = 0;
  int errors = 0;
  int edge_count = 0;
  int sample_edge = 0;

  typedef struct { int due; logic [W-1:0] data; logic sat; } exp_t;
  typedef struct { int at;  logic [W-1:0] data; logic sat; } cap_t;

  exp_t exp0[$];
  exp_t exp1[$];
  cap_t cap0[$];
  cap_t cap1[$];
  logic [W-1:0] held_d[2];
  logic         held_s[2];

  longint vec_sum;
  bit     first_beat;

  pipe_sum_tree_acc #(.WORD_LEN(W), .LANES(LANES), .ACC_GUARD(GUARD), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid0), .out_data(out_data0), .out_sat(out_sat0));

  pipe_sum_tree_acc #(.WORD_LEN(W), .LANES(LANES), .ACC_GUARD(GUARD), .OUT_SHIFT(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1));

  always #5 clk = ~clk;

  // Model: whole-vector integer sum, wrapped to ACC_W, floor-shifted, then clamped or wrapped.
  function automatic longint wrap_acc(input longint v);
    longint t;
    t = v <<< (64 - ACC_W);
    return t >>> (64 - ACC_W);
  endfunction

  function automatic void expect_result(input longint acc, input int sh,
                                        output logic [W-1:0] d, output logic s);
    longint r, maxv, minv;
    r    = acc >>> sh;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -maxv - 1;
`ifdef SUM_TREE_SAT_EN
    if (r > maxv) begin
      d = maxv[W-1:0]; s = 1'b1;
    end else if (r < minv) begin
      d = minv[W-1:0]; s = 1'b1;
    end else begin
      d = r[W-1:0]; s = 1'b0;
    end
`else
    d = r[W-1:0];
    s = 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    longint bsum;
    exp_t   e;
    edge_count = edge_count + 1;
    if (rst) begin
      vec_sum    = 0;
      first_beat = 1'b1;
      exp0.delete();
      exp1.delete();
    end else if (in_valid) begin
      bsum = 0;
      for (int i = 0; i < LANES; i++) bsum += longint'($signed(in_data[i*W +: W]));
      vec_sum    = wrap_acc(first_beat ? bsum : vec_sum + bsum);
      first_beat = in_last;
      if (in_last) begin
        e.due = edge_count + LAT;
        expect_result(vec_sum, 0, e.data, e.sat);
        exp0.push_back(e);
        expect_result(vec_sum, 1, e.data, e.sat);
        exp1.push_back(e);
      end
    end
  end

  task automatic compareOne(input int which, input logic v, input logic [W-1:0] d, input logic s);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (which == 0) begin
      if (exp0.size() > 0 && exp0[0].due == edge_count) begin e = exp0.pop_front(); have = 1'b1; end
    end else begin
      if (exp1.size() > 0 && exp1[0].due == edge_count) begin e = exp1.pop_front(); have = 1'b1; end
    end
    checks++;
    if (have) begin
      if (v !== 1'b1 || d !== e.data || s !== e.sat) begin
        errors++;
        $display("[TB] FAIL pulse%0d edge %0d: got v=%0b d=%h s=%0b, want v=1 d=%h s=%0b",
                 which, edge_count, v, d, s, e.data, e.sat);
      end
      held_d[which] = e.data;
      held_s[which] = e.sat;
    end else if (v !== 1'b0 || d !== held_d[which] || s !== held_s[which]) begin
      errors++;
      $display("[TB] FAIL idle%0d edge %0d: got v=%0b d=%h s=%0b, want v=0 d=%h s=%0b",
               which, edge_count, v, d, s, held_d[which], held_s[which]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp0.delete();
      exp1.delete();
      held_d[0] = '0; held_d[1] = '0;
      held_s[0] = 1'b0; held_s[1] = 1'b0;
      checks++;
      if ({out_valid0, out_data0, out_sat0, out_valid1, out_data1, out_sat1} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outs edge %0d: got v0=%0b d0=%h s0=%0b v1=%0b d1=%h s1=%0b, want all 0",
                 edge_count, out_valid0, out_data0, out_sat0, out_valid1, out_data1, out_sat1);
      end
    end else begin
      compareOne(0, out_valid0, out_data0, out_sat0);
      compareOne(1, out_valid1, out_data1, out_sat1);
    end
  end

  always @(negedge clk) begin
    cap_t c;
    if (!rst) begin
      if (out_valid0) begin c.at = edge_count; c.data = out_data0; c.sat = out_sat0; cap0.push_back(c); end
      if (out_valid1) begin c.at = edge_count; c.data = out_data1; c.sat = out_sat1; cap1.push_back(c); end
    end
  end

  task automatic applyStimulus(input logic v, input logic l, input logic [LANES*W-1:0] d);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_last     = l;
    in_data     = d;
    sample_edge = edge_count + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input cap_t c, input logic [W-1:0] d,
                             input logic s, input int at);
    checks++;
    if (c.data !== d || c.sat !== s || c.at != at) begin
      errors++;
      $display("[TB] FAIL %s: got d=%h s=%0b edge=%0d, want d=%h s=%0b edge=%0d",
               name, c.data, c.sat, c.at, d, s, at);
    end
  endtask

  function automatic cap_t getCap(input int which, input int idx);
    cap_t c;
    c.at = -1; c.data = 'x; c.sat = 1'bx;
    if (which == 0 && idx < cap0.size()) c = cap0[idx];
    if (which == 1 && idx < cap1.size()) c = cap1[idx];
    return c;
  endfunction

  function automatic logic [LANES*W-1:0] fill(input logic [W-1:0] v);
    logic [LANES*W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [LANES*W-1:0] ramp();
    logic [LANES*W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W +: W] = W'(i + 1);
    return r;
  endfunction

  function automatic logic [LANES*W-1:0] rand_beat();
    logic [LANES*W-1:0] r;
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0:       r[i*W +: W] = W'($urandom_range(0, 200)) - W'(100);
        1, 2:    r[i*W +: W] = $urandom;
        default: r[i*W +: W] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
    end
    return r;
  endfunction

  initial begin
    int e;
    logic [LANES*W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkVal("reset_state", {out_valid0, out_data0, out_sat0}, '0);

    cap0.delete(); cap1.delete();
    applyStimulus(1'b1, 1'b1, fill(32'd1)); e = sample_edge;
    idle(8);
    checkVal("single_count", cap0.size(), 1);
    checkOutput("single_beat", getCap(0, 0), 32'd8, 1'b0, e + 4);

    cap0.delete(); cap1.delete();
    applyStimulus(1'b1, 1'b0, ramp());
    applyStimulus(1'b1, 1'b0, ramp());
    idle(2);
    applyStimulus(1'b1, 1'b1, ramp()); e = sample_edge;
    idle(8);
    checkVal("gap_count", cap0.size(), 1);
    checkOutput("gap_vector", getCap(0, 0), 32'd108, 1'b0, e + 4);

    cap0.delete(); cap1.delete();
    applyStimulus(1'b1, 1'b1, fill(32'hFFFF_FFFF)); e = sample_edge;
    applyStimulus(1'b1, 1'b1, fill(32'd2));
    idle(8);
    checkVal("b2b_count", cap0.size(), 2);
    checkOutput("b2b_first", getCap(0, 0), 32'hFFFF_FFF8, 1'b0, e + 4);
    checkOutput("b2b_second", getCap(0, 1), 32'd16, 1'b0, e + 5);

    cap0.delete(); cap1.delete();
    applyStimulus(1'b1, 1'b1, fill(32'h7FFF_FFFF)); e = sample_edge;
    idle(8);
`ifdef SUM_TREE_SAT_EN
    checkOutput("max_lanes", getCap(0, 0), 32'h7FFF_FFFF, 1'b1, e + 4);
`else
    checkOutput("max_lanes", getCap(0, 0), 32'hFFFF_FFF8, 1'b0, e + 4);
`endif

    cap0.delete(); cap1.delete();
    d = '0; d[W-1:0] = 32'd7;
    applyStimulus(1'b1, 1'b1, d); e = sample_edge;
    d[W-1:0] = 32'hFFFF_FFF9;
    applyStimulus(1'b1, 1'b1, d);
    idle(8);
    checkOutput("shift_pos", getCap(1, 0), 32'd3, 1'b0, e + 4);
    checkOutput("shift_neg", getCap(1, 1), 32'hFFFF_FFFC, 1'b0, e + 5);

    cap0.delete(); cap1.delete();
    applyStimulus(1'b1, 1'b0, fill(32'd1000));
    applyStimulus(1'b1, 1'b0, fill(32'd1000));
    doReset(2);
    checkVal("reset_midvec_out", {out_valid0, out_data0, out_sat0}, '0);
    applyStimulus(1'b1, 1'b1, fill(32'd1)); e = sample_edge;
    idle(8);
    checkVal("reset_count", cap0.size(), 1);
    checkOutput("reset_fresh", getCap(0, 0), 32'd8, 1'b0, e + 4);

    repeat (300) applyStimulus(1'b1, 1'b0, fill(32'h7FFF_FFFF));
    applyStimulus(1'b1, 1'b1, fill(32'h7FFF_FFFF));
    idle(8);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset($urandom_range(1, 3));
      end else begin
        applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, rand_beat());
      end
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
